// File: rtl/mem_bus_scheduler_pkg.sv
// Shared types, constants and helpers for the byte-serial memory bus scheduler.
package mem_bus_pkg;

  // funct3 access codes; stores share the load encodings
  localparam logic [2:0] T_LB  = 3'b000;
  localparam logic [2:0] T_LH  = 3'b001;
  localparam logic [2:0] T_LW  = 3'b010;
  localparam logic [2:0] T_LBU = 3'b100;
  localparam logic [2:0] T_LHU = 3'b101;
  localparam logic [2:0] T_SB  = 3'b000;
  localparam logic [2:0] T_SH  = 3'b001;
  localparam logic [2:0] T_SW  = 3'b010;

  // address bits [17:16] selecting the IO space
  localparam logic [1:0] IO_SEL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // latched request of the granted requester
  typedef struct packed {
    logic        ic;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  typ;
    logic [31:0] wdata;
  } req_t;

  // number of byte beats; only type[1:0] matters, unknown sizes become words
  function automatic logic [2:0] beat_count(input logic [2:0] t);
    logic [2:0] n;
    case (t[1:0])
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // sign/zero extension of the assembled read word
  function automatic logic [31:0] extend(input logic [2:0] t, input logic [31:0] raw);
    logic [31:0] r;
    case (t)
      T_LB:    r = {{24{raw[7]}}, raw[7:0]};
      T_LH:    r = {{16{raw[15]}}, raw[15:0]};
      T_LBU:   r = {24'h000000, raw[7:0]};
      T_LHU:   r = {16'h0000, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  // byte lane i of a store word
  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_bus_scheduler_if.sv
// Requester and RAM/IO port signals of the scheduler; slave = scheduler side.
interface mem_bus_scheduler_if;
  logic        flush;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic [2:0]  ic_type;
  logic        ic_done;
  logic        ls_req;
  logic        ls_wr;
  logic [31:0] ls_addr;
  logic [2:0]  ls_type;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport slave (
    input  flush, ic_req, ic_addr, ic_type, ls_req, ls_wr, ls_addr, ls_type, ls_wdata,
           mem_din, io_buffer_full,
    output ic_done, ls_done, rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output flush, ic_req, ic_addr, ic_type, ls_req, ls_wr, ls_addr, ls_type, ls_wdata,
           mem_din, io_buffer_full,
    input  ic_done, ls_done, rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_bus_scheduler_rr_arb2.sv
// Two-way round-robin arbiter (icache vs load/store buffer).
module rr_arb2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic served_ic_i,
  input  logic tie_ic_i,
  input  logic req_ic_i,
  input  logic req_ls_i,
  output logic gnt_ic_o,
  output logic gnt_ls_o
);
  logic last_ic_q;
  logic last_ic_d;

  // remember who was served last; reset as if the icache had been served
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_ic_q <= 1'b1;
    end else begin
      last_ic_q <= last_ic_d;
    end
  end

  // update on completion and resolve ties toward the other requester
  always_comb begin
    if (en_i) begin
      last_ic_d = served_ic_i;
    end else begin
      last_ic_d = last_ic_q;
    end
    gnt_ic_o = req_ic_i & (~req_ls_i | tie_ic_i | ~last_ic_q);
    gnt_ls_o = req_ls_i & ~gnt_ic_o;
  end
endmodule

// File: rtl/mem_bus_scheduler.sv
// Byte-serial RAM/IO port scheduler for icache reads and LSB loads/stores.
module mem_bus_scheduler
  import mem_bus_pkg::*;
#(
  parameter int IO_GAP             = 1,
  parameter bit ICACHE_PRIO_ON_TIE = 1'b0
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  mem_bus_scheduler_if.slave   bus
);
  localparam logic [3:0] GAP_LD = 4'(IO_GAP);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic [3:0]  gap_q, gap_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  dout_q, dout_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ic_done_q, ic_done_d;
  logic        ls_done_q, ls_done_d;

  logic        gnt_ic_s, gnt_ls_s;
  logic [2:0]  n_s, nxt_cnt_s;
  logic        stall_s, abort_s, io_beat_s;
  logic [31:0] asm_s;

  assign n_s       = beat_count(req_q.typ);
  assign nxt_cnt_s = cnt_q + 3'd1;
  // an IO write beat waits while the UART is full or the gap has not elapsed
  assign stall_s   = (state_q == WRITE) && (mem_a_q[17:16] == IO_SEL)
                     && (bus.io_buffer_full || (gap_q != 4'd0));
  assign io_beat_s = (state_q == WRITE) && !stall_s && (mem_a_q[17:16] == IO_SEL);
  assign abort_s   = (state_q == READ) && req_q.ic && bus.flush;

  rr_arb2 u_arb (
    .clk_i       (clk_in),
    .rst_ni      (rst_in),
    .en_i        (rdy_in && (state_q == DONE)),
    .served_ic_i (req_q.ic),
    .tie_ic_i    (ICACHE_PRIO_ON_TIE),
    .req_ic_i    (bus.ic_req && !bus.flush),
    .req_ls_i    (bus.ls_req),
    .gnt_ic_o    (gnt_ic_s),
    .gnt_ls_o    (gnt_ls_s)
  );

  // merge the byte arriving on mem_din into the lane of the previous beat
  always_comb begin
    case (cnt_q)
      3'd1:    asm_s = {buf_q[31:8], bus.mem_din};
      3'd2:    asm_s = {buf_q[31:16], bus.mem_din, buf_q[7:0]};
      3'd3:    asm_s = {buf_q[31:24], bus.mem_din, buf_q[15:0]};
      3'd4:    asm_s = {bus.mem_din, buf_q[23:0]};
      default: asm_s = buf_q;
    endcase
  end

  // state and datapath registers; rdy_in low freezes everything
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      req_q     <= '0;
      cnt_q     <= 3'd0;
      buf_q     <= 32'h0;
      gap_q     <= 4'd0;
      mem_a_q   <= 32'h0;
      dout_q    <= 8'h00;
      wr_q      <= 1'b0;
      rdata_q   <= 32'h0;
      ic_done_q <= 1'b0;
      ls_done_q <= 1'b0;
    end else if (rdy_in) begin
      state_q   <= state_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      gap_q     <= gap_d;
      mem_a_q   <= mem_a_d;
      dout_q    <= dout_d;
      wr_q      <= wr_d;
      rdata_q   <= rdata_d;
      ic_done_q <= ic_done_d;
      ls_done_q <= ls_done_d;
    end else begin
      state_q   <= state_q;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt_ic_s) begin
          state_d = READ;
        end else if (gnt_ls_s) begin
          state_d = bus.ls_wr ? WRITE : READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (abort_s) begin
          state_d = IDLE;
        end else if (cnt_q == n_s) begin
          state_d = DONE;
        end else begin
          state_d = READ;
        end
      end
      WRITE: begin
        if (!stall_s && (cnt_q == n_s - 3'd1)) begin
          state_d = DONE;
        end else begin
          state_d = WRITE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // bus outputs, beat counter, byte assembly and done pulses
  always_comb begin
    req_d     = req_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    mem_a_d   = mem_a_q;
    dout_d    = dout_q;
    wr_d      = wr_q;
    rdata_d   = rdata_q;
    ic_done_d = 1'b0;
    ls_done_d = 1'b0;
    if (io_beat_s) begin
      gap_d = GAP_LD;
    end else if (gap_q != 4'd0) begin
      gap_d = gap_q - 4'd1;
    end else begin
      gap_d = 4'd0;
    end
    case (state_q)
      IDLE: begin
        mem_a_d = 32'h0;
        wr_d    = 1'b0;
        cnt_d   = 3'd0;
        if (gnt_ic_s) begin
          req_d   = '{ic: 1'b1, wr: 1'b0, addr: bus.ic_addr, typ: bus.ic_type, wdata: 32'h0};
          mem_a_d = bus.ic_addr;
        end else if (gnt_ls_s) begin
          req_d   = '{ic: 1'b0, wr: bus.ls_wr, addr: bus.ls_addr, typ: bus.ls_type,
                      wdata: bus.ls_wdata};
          mem_a_d = bus.ls_addr;
          dout_d  = bus.ls_wr ? bus.ls_wdata[7:0] : dout_q;
          wr_d    = bus.ls_wr;
        end else begin
          req_d   = req_q;
        end
      end
      READ: begin
        if (abort_s) begin
          mem_a_d = 32'h0;
        end else if (cnt_q == n_s) begin
          buf_d     = asm_s;
          rdata_d   = extend(req_q.typ, asm_s);
          ic_done_d = req_q.ic;
          ls_done_d = !req_q.ic;
          mem_a_d   = 32'h0;
        end else begin
          buf_d   = asm_s;
          cnt_d   = nxt_cnt_s;
          mem_a_d = (nxt_cnt_s < n_s) ? (req_q.addr + {29'd0, nxt_cnt_s}) : 32'h0;
        end
      end
      WRITE: begin
        if (stall_s) begin
          cnt_d = cnt_q;
        end else if (cnt_q == n_s - 3'd1) begin
          ls_done_d = 1'b1;
          mem_a_d   = 32'h0;
          dout_d    = 8'h00;
          wr_d      = 1'b0;
        end else begin
          cnt_d   = nxt_cnt_s;
          mem_a_d = req_q.addr + {29'd0, nxt_cnt_s};
          dout_d  = get_byte(req_q.wdata, nxt_cnt_s[1:0]);
        end
      end
      default: begin
        mem_a_d = 32'h0;
        wr_d    = 1'b0;
      end
    endcase
  end

  assign bus.mem_a    = stall_s ? 32'h0 : mem_a_q;
  assign bus.mem_wr   = wr_q && !stall_s;
  assign bus.mem_dout = dout_q;
  assign bus.rdata    = rdata_q;
  assign bus.ic_done  = ic_done_q;
  assign bus.ls_done  = ls_done_q;
endmodule

// File: tb/tb_mem_bus_scheduler.sv
// Directed bench with done/write scoreboards checked by a negedge monitor.
module tb_mem_bus_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  typedef struct { bit ic; logic [31:0] rd; int cy; } done_t;
  typedef struct { logic [31:0] a; logic [7:0] d; int cy; } wr_t;
  done_t dq[$];
  wr_t   wq[$];

  bit [7:0]  mem [bit [31:0]];
  bit [31:0] pend_a = 32'h0;

  mem_bus_scheduler_if bus ();

  mem_bus_scheduler #(.IO_GAP(1), .ICACHE_PRIO_ON_TIE(1'b0)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .rdy_in (rdy),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // RAM model: address seen in a cycle returns its byte in the next cycle
  always @(negedge clk) begin
    pend_a = bus.mem_a;
    if (bus.mem_wr === 1'b1) mem[bus.mem_a] = bus.mem_dout;
  end
  always @(posedge clk) begin
    #1;
    bus.mem_din = mem.exists(pend_a) ? mem[pend_a] : 8'h00;
  end

  // monitor: pop and compare on every done pulse and write beat
  always @(negedge clk) begin
    if (bus.ic_done === 1'b1 || bus.ls_done === 1'b1) begin
      chk("done_onehot", {31'd0, bus.ic_done & bus.ls_done}, 32'd0);
      if (dq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        done_t e;
        e = dq.pop_front();
        chk("done_who_ic", {31'd0, bus.ic_done}, {31'd0, e.ic});
        chk("done_cycle", cyc, e.cy);
        chk("done_rdata", bus.rdata, e.rd);
      end
    end
    if (bus.mem_wr === 1'b1) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", bus.mem_a, 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_addr", bus.mem_a, w.a);
        chk("wr_data", {24'd0, bus.mem_dout}, {24'd0, w.d});
        chk("wr_cycle", cyc, w.cy);
      end
    end
  end

  task automatic go(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ic_set(input logic r, input logic [31:0] a, input logic [2:0] t);
    bus.ic_req = r; bus.ic_addr = a; bus.ic_type = t;
  endtask

  task automatic ls_set(input logic r, input logic w, input logic [31:0] a,
                        input logic [2:0] t, input logic [31:0] wd);
    bus.ls_req = r; bus.ls_wr = w; bus.ls_addr = a; bus.ls_type = t; bus.ls_wdata = wd;
  endtask

  task automatic exp_done(input bit ic, input logic [31:0] rd, input int cy);
    done_t e;
    e.ic = ic; e.rd = rd; e.cy = cy;
    dq.push_back(e);
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [7:0] d, input int cy);
    wr_t w;
    w.a = a; w.d = d; w.cy = cy;
    wq.push_back(w);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bus.flush = 1'b0;
    bus.io_buffer_full = 1'b0;
    bus.mem_din = 8'h00;
    ic_set(1'b0, 32'h0, 3'b000);
    ls_set(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
    mem[32'h200] = 8'h80;
    mem[32'h300] = 8'hFE; mem[32'h301] = 8'h81;

    // reset values
    go(3);
    @(negedge clk);
    chk("rst_mem_a", bus.mem_a, 32'h0);
    chk("rst_mem_dout", {24'd0, bus.mem_dout}, 32'h0);
    chk("rst_mem_wr", {31'd0, bus.mem_wr}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_ic_done", {31'd0, bus.ic_done}, 32'h0);
    chk("rst_ls_done", {31'd0, bus.ls_done}, 32'h0);

    // both requesting from reset: LSB, then icache, then LSB again
    go(1); c = cyc;
    rst_n = 1'b1;
    ic_set(1'b1, 32'h100, 3'b010);
    ls_set(1'b1, 1'b0, 32'h200, 3'b000, 32'h0);
    exp_done(1'b0, 32'hFFFF_FF80, c + 3);
    exp_done(1'b1, 32'h4433_2211, c + 10);
    exp_done(1'b0, 32'h0000_0080, c + 14);
    go(1); @(negedge clk);
    chk("tie_first_ls_addr", bus.mem_a, 32'h200);
    go(2); bus.ls_type = 3'b100;
    go(2); @(negedge clk);
    chk("tie_second_ic_addr", bus.mem_a, 32'h100);
    go(5); bus.ic_req = 1'b0;
    go(4); bus.ls_req = 1'b0;

    // icache LW with per-beat address check
    go(2); c = cyc;
    ic_set(1'b1, 32'h100, 3'b010);
    exp_done(1'b1, 32'h4433_2211, c + 6);
    for (int i = 0; i < 4; i++) begin
      go(1); @(negedge clk);
      chk("lw_beat_addr", bus.mem_a, 32'h100 + 32'(i));
      chk("lw_beat_rd", {31'd0, bus.mem_wr}, 32'h0);
    end
    go(2); bus.ic_req = 1'b0;

    // LB then LBU of 0x80
    go(1); c = cyc;
    ls_set(1'b1, 1'b0, 32'h200, 3'b000, 32'h0);
    exp_done(1'b0, 32'hFFFF_FF80, c + 3);
    go(3); bus.ls_req = 1'b0;
    go(1); c = cyc;
    ls_set(1'b1, 1'b0, 32'h200, 3'b100, 32'h0);
    exp_done(1'b0, 32'h0000_0080, c + 3);
    go(3); bus.ls_req = 1'b0;

    // SW to UART space with back-pressure and write gap
    go(1); c = cyc;
    ls_set(1'b1, 1'b1, 32'h0003_0000, 3'b010, 32'h0000_0A41);
    exp_wr(32'h0003_0000, 8'h41, c + 4);
    exp_wr(32'h0003_0001, 8'h0A, c + 6);
    exp_wr(32'h0003_0002, 8'h00, c + 8);
    exp_wr(32'h0003_0003, 8'h00, c + 10);
    exp_done(1'b0, 32'h0000_0080, c + 11);
    go(1); bus.io_buffer_full = 1'b1;
    @(negedge clk);
    chk("io_full_wr", {31'd0, bus.mem_wr}, 32'h0);
    chk("io_full_addr", bus.mem_a, 32'h0);
    go(2); @(negedge clk);
    chk("io_full_wr_c3", {31'd0, bus.mem_wr}, 32'h0);
    go(1); bus.io_buffer_full = 1'b0;
    @(negedge clk);
    chk("io_first_wr", {31'd0, bus.mem_wr}, 32'h1);
    go(1); @(negedge clk);
    chk("io_gap_wr", {31'd0, bus.mem_wr}, 32'h0);
    go(6); bus.ls_req = 1'b0; bus.ls_wr = 1'b0;

    // flush mid icache LW; pending LB granted from IDLE
    go(1); c = cyc;
    ic_set(1'b1, 32'h100, 3'b010);
    go(1);
    ls_set(1'b1, 1'b0, 32'h200, 3'b000, 32'h0);
    exp_done(1'b0, 32'hFFFF_FF80, c + 7);
    go(2); bus.flush = 1'b1; bus.ic_req = 1'b0;
    go(1); bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_addr", bus.mem_a, 32'h0);
    chk("flush_rdata", bus.rdata, 32'h0000_0080);
    go(1); @(negedge clk);
    chk("flush_ls_addr", bus.mem_a, 32'h200);
    go(2); bus.ls_req = 1'b0;

    // LH with rdy_in low for five cycles
    go(1); c = cyc;
    ls_set(1'b1, 1'b0, 32'h300, 3'b001, 32'h0);
    exp_done(1'b0, 32'hFFFF_81FE, c + 9);
    go(1); rdy = 1'b0;
    @(negedge clk);
    chk("frz_addr_a", bus.mem_a, 32'h300);
    go(2); @(negedge clk);
    chk("frz_addr_b", bus.mem_a, 32'h300);
    chk("frz_rdata", bus.rdata, 32'hFFFF_FF80);
    go(3); rdy = 1'b1;
    go(1); @(negedge clk);
    chk("resume_addr", bus.mem_a, 32'h301);
    go(2); bus.ls_req = 1'b0;

    // reset in the middle of a RAM SW
    go(1); c = cyc;
    ls_set(1'b1, 1'b1, 32'h400, 3'b010, 32'hDEAD_BEEF);
    exp_wr(32'h400, 8'hEF, c + 1);
    exp_wr(32'h401, 8'hBE, c + 2);
    go(2); rst_n = 1'b0; bus.ls_req = 1'b0; bus.ls_wr = 1'b0;
    go(1); @(negedge clk);
    chk("srst_mem_a", bus.mem_a, 32'h0);
    chk("srst_mem_wr", {31'd0, bus.mem_wr}, 32'h0);
    chk("srst_mem_dout", {24'd0, bus.mem_dout}, 32'h0);
    chk("srst_rdata", bus.rdata, 32'h0);
    chk("srst_ls_done", {31'd0, bus.ls_done}, 32'h0);
    go(1); rst_n = 1'b1;

    // after reset the tie goes to the LSB again
    go(1); c = cyc;
    ic_set(1'b1, 32'h200, 3'b000);
    ls_set(1'b1, 1'b0, 32'h200, 3'b100, 32'h0);
    exp_done(1'b0, 32'h0000_0080, c + 3);
    exp_done(1'b1, 32'hFFFF_FF80, c + 7);
    go(3); bus.ls_req = 1'b0;
    go(4); bus.ic_req = 1'b0;

    go(4);
    chk("done_queue_empty", dq.size(), 32'd0);
    chk("write_queue_empty", wq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mem_bus_scheduler.md
Name: mem_bus_scheduler

Overview:
- Sequences all traffic on the single byte-wide RAM/IO port.
- Arbitrates between two requesters:
  - the instruction cache, which only reads;
  - the load/store buffer, which reads and writes.
- Each granted request is split into 1/2/4 byte-serial beats, honouring the 1-cycle RAM read latency and the UART `io_buffer_full` back-pressure.
- Read bytes are assembled into a sign- or zero-extended 32-bit result with a one-cycle done pulse per requester.

Parameters:
- IO_GAP, 1: idle cycles forced after any IO-space write beat before the next IO write beat.
- ICACHE_PRIO_ON_TIE, 0: on a tie, 0 gives the grant to the requester not served last; 1 always grants the icache.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous reset, active-low
- rdy_in  in  1  global enable; low freezes all state and outputs
- flush  in  1  branch mispredict; aborts icache traffic only
- ic_req  in  1  icache request; level, held until ic_done or flush
- ic_addr  in  32  icache byte address
- ic_type  in  3  access type (encoding below)
- ic_done  out  1  one-cycle pulse; rdata valid
- ls_req  in  1  LSB request; level, held until ls_done
- ls_wr  in  1  1 = store
- ls_addr  in  32  LSB byte address
- ls_type  in  3  access type
- ls_wdata  in  32  store data; bytes sent LSB first
- ls_done  out  1  one-cycle pulse; load data valid, or store finished
- rdata  out  32  extended load result, shared by both requesters
- mem_din  in  8  RAM/IO read byte, valid the cycle after its address
- mem_dout  out  8  write byte
- mem_a  out  32  byte address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  UART TX full

Behaviour:
- Type encoding (funct3):
  - 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
  - Beat count N = 1/2/4 from type[1:0].
  - Stores ignore type[2].
  - Other encodings are treated as a 4-byte access.
- Reset (rst_in low at a clock edge):
  - state=IDLE.
  - mem_a=0, mem_dout=0, mem_wr=0.
  - rdata=0, ic_done=0, ls_done=0.
  - last_grant=icache, io_gap counter=0.
- rdy_in low: no state, counter or output register changes.
- States: IDLE -> READ or WRITE -> DONE -> IDLE.
- IDLE:
  - Bus is quiescent: mem_a=0, mem_wr=0.
  - Requests are sampled; if both are high, the round-robin rule picks one (reset tie goes to the LSB).
  - The chosen request's addr/type/wdata/wr are latched.
  - flush blocks ic_req in that cycle.
- Read timing, request sampled in cycle c:
  - mem_a = addr+i in cycle c+1+i, for i = 0..N-1, with mem_wr=0.
  - Byte i is captured from mem_din in cycle c+2+i.
  - Done pulse and final rdata appear in cycle c+N+2: LB = c+3, LW = c+6.
- Write timing, no stall:
  - mem_a = addr+i, mem_dout = wdata[8i+7:8i], mem_wr=1, in cycles c+1..c+N.
  - Done pulse in cycle c+N+1.
- Address arithmetic:
  - Addresses are 32-bit, increment by 1 and wrap modulo 2^32.
  - No alignment check.
- IO write stall:
  - Applies when addr[17:16]==2'b11 and either io_buffer_full=1 or the io_gap counter is nonzero.
  - During a stall: mem_wr=0, mem_a=0, and the beat is retried next cycle.
  - After each IO write beat the io_gap counter loads IO_GAP and counts down.
  - IO reads are never stalled.
- Extension:
  - LB and LH sign-extend from bit 7 and bit 15.
  - LBU and LHU zero-extend.
  - rdata holds its value until the next read completes.
- DONE state:
  - Exactly one of ic_done/ls_done is high for one cycle; last_grant is updated.
  - A new request can be sampled no earlier than the cycle after DONE, giving a 1-cycle bubble.
- flush during an icache READ:
  - The next cycle returns to IDLE with mem_a=0.
  - No ic_done is issued and rdata is not updated.
  - An ic_done already high in the flush cycle stays high; the icache must discard it.
- flush never affects an LSB transaction: stores must complete, and an IO read at 0x30000 must not be re-issued.
- No back-to-back grant to the same requester while the other is waiting (unless ICACHE_PRIO_ON_TIE=1).

Decomposition:
- mem_bus_pkg holds:
  - type codes (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - state enum (IDLE, READ, WRITE, DONE);
  - IO_SEL=2'b11;
  - beat-count function.
- One sub-module, rr_arb2: 2-way round-robin arbiter with last_grant register and tie-priority input.

Test Plan:
- LW at 0x100, RAM bytes 0x11,0x22,0x33,0x44; ic_req in cycle c -> mem_a 0x100..0x103 in c+1..c+4; ic_done in c+6; rdata=0x44332211.
- LB at 0x200 = 0x80, then LBU at the same address -> rdata=0xFFFFFF80, then 0x00000080; each ls_done at c+3.
- ic_req and ls_req both high from reset -> LSB granted first, icache next, no done overlap; then re-assert both -> icache wins the tie.
- SW 0x00000A41 to 0x30000 with io_buffer_full high for cycles c+1..c+3 -> no mem_wr until c+4, each IO byte separated by ≥1 idle cycle, ls_done after the last byte.
- flush in the 3rd cycle of an icache LW -> mem_a=0 next cycle, no ic_done, rdata unchanged; a pending ls_req is granted from IDLE.
- rdy_in low for 5 cycles mid-LH, plus reset low mid-SW -> LH: outputs frozen, completes with the correct value after resume; SW: all outputs 0 next cycle, state IDLE.
